// File: rtl/s13207_sel_sched_if.sv
// Bus bundle between requesters, the shared select mux and the scheduler.
// SCHED_ERRCHK_EN adds the rerr read-error flag.
interface s13207_sel_sched_if;
    logic [3:0]  req;
    logic [15:0] req_sel;
    logic        mux_dout;
    logic [3:0]  mux_sel;
    logic        mux_en;
    logic [3:0]  gnt;
    logic        rdata;
    logic        rvalid;
    logic [1:0]  rid;
    logic        busy;
`ifdef SCHED_ERRCHK_EN
    logic        rerr;

    modport slave  (input  req, req_sel, mux_dout,
                    output mux_sel, mux_en, gnt, rdata, rvalid, rid, busy, rerr);
    modport master (output req, req_sel, mux_dout,
                    input  mux_sel, mux_en, gnt, rdata, rvalid, rid, busy, rerr);
`else
    modport slave  (input  req, req_sel, mux_dout,
                    output mux_sel, mux_en, gnt, rdata, rvalid, rid, busy);
    modport master (output req, req_sel, mux_dout,
                    input  mux_sel, mux_en, gnt, rdata, rvalid, rid, busy);
`endif
endinterface

// File: rtl/s13207_sel_sched.sv
// Round-robin scheduler for four requesters sharing one decoded-select read mux.
// SCHED_ERRCHK_EN adds a CHECK state that double-samples mux_dout and flags rerr.
module s13207_sel_sched #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                 CK,
    input  logic                 RN,
    s13207_sel_sched_if.slave    bus
);

`ifdef SCHED_ERRCHK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK} state_e;
    logic samp_q, rerr_q;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE} state_e;
`endif

    state_e      state_q;
    logic [1:0]  ptr_q, win_q, rid_q;
    logic [3:0]  cnt_q, sel_q, gnt_q;
    logic        en_q, rdata_q, rvalid_q;
    logic [1:0]  win_d, idx;
    logic        any_d;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        win_d = ptr_q;
        any_d = 1'b0;
        idx   = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (bus.req[idx]) begin
                win_d = idx;
                any_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
            en_q     <= 1'b0;
            rdata_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
`ifdef SCHED_ERRCHK_EN
            samp_q   <= 1'b0;
            rerr_q   <= 1'b0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_d) begin
                        gnt_q   <= 4'b0001 << win_d;
                        sel_q   <= bus.req_sel[{win_d, 2'b00} +: 4];
                        en_q    <= 1'b1;
                        cnt_q   <= 4'(SETTLE - 1);
                        win_q   <= win_d;
                        ptr_q   <= win_d + 2'd1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
`ifdef SCHED_ERRCHK_EN
                        samp_q   <= bus.mux_dout;
                        state_q  <= ST_CHECK;
`else
                        rdata_q  <= bus.mux_dout;
                        rid_q    <= win_q;
                        rvalid_q <= 1'b1;
                        gnt_q    <= '0;
                        en_q     <= 1'b0;
                        state_q  <= ST_IDLE;
`endif
                    end
                end
`ifdef SCHED_ERRCHK_EN
                ST_CHECK: begin
                    rdata_q  <= samp_q;
                    rerr_q   <= samp_q ^ bus.mux_dout;
                    rid_q    <= win_q;
                    rvalid_q <= 1'b1;
                    gnt_q    <= '0;
                    en_q     <= 1'b0;
                    state_q  <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mux_sel = sel_q;
    assign bus.mux_en  = en_q;
    assign bus.gnt     = gnt_q;
    assign bus.rdata   = rdata_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rid     = rid_q;
    assign bus.busy    = (state_q != ST_IDLE);
`ifdef SCHED_ERRCHK_EN
    assign bus.rerr    = rerr_q;
`endif

endmodule

// File: tb/tb_s13207_sel_sched.sv
// Bench for s13207_sel_sched: three instances (SETTLE=2,1,15) share one stimulus
// and are each compared against a transaction-level timing model every cycle.
module tb_s13207_sel_sched;

`ifdef SCHED_ERRCHK_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic        CK, RN;
    logic [3:0]  t_req;
    logic [15:0] t_sel;
    logic        t_dout;
    int          tests, fails;
    bit          chk_en;

    s13207_sel_sched_if if2();
    s13207_sel_sched_if if1();
    s13207_sel_sched_if if15();

    assign if2.req  = t_req;  assign if2.req_sel  = t_sel;  assign if2.mux_dout  = t_dout;
    assign if1.req  = t_req;  assign if1.req_sel  = t_sel;  assign if1.mux_dout  = t_dout;
    assign if15.req = t_req;  assign if15.req_sel = t_sel;  assign if15.mux_dout = t_dout;

    s13207_sel_sched #(.SETTLE(2))  u_d2  (.CK(CK), .RN(RN), .bus(if2));
    s13207_sel_sched #(.SETTLE(1))  u_d1  (.CK(CK), .RN(RN), .bus(if1));
    s13207_sel_sched #(.SETTLE(15)) u_d15 (.CK(CK), .RN(RN), .bus(if15));

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {gnt[4], mux_sel[4], mux_en, rvalid, rdata, rid[2], busy, rerr}
    function automatic logic [14:0] obs(input int k);
        logic e2, e1, e15;
`ifdef SCHED_ERRCHK_EN
        e2 = if2.rerr; e1 = if1.rerr; e15 = if15.rerr;
`else
        e2 = 1'b0; e1 = 1'b0; e15 = 1'b0;
`endif
        case (k)
            0:       return {if2.gnt, if2.mux_sel, if2.mux_en, if2.rvalid, if2.rdata, if2.rid, if2.busy, e2};
            1:       return {if1.gnt, if1.mux_sel, if1.mux_en, if1.rvalid, if1.rdata, if1.rid, if1.busy, e1};
            default: return {if15.gnt, if15.mux_sel, if15.mux_en, if15.rvalid, if15.rdata, if15.rid, if15.busy, e15};
        endcase
    endfunction

    // Timing model: a transaction granted at edge t samples the mux at edge t+S
    // (and t+S+1 for the error check) and completes on its last sample edge.
    int         S [3] = '{2, 1, 15};
    int         cyc = 0;
    bit         m_busy [3], m_rv [3], m_rdata [3], m_rerr [3], m_first [3];
    int         m_start [3], m_w [3], m_ptr [3], m_rid [3];
    logic [3:0] m_sel [3];

    initial forever begin
        @(posedge CK or negedge RN);
        if (!RN) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] = 0; m_rv[k] = 0; m_rdata[k] = 0; m_rerr[k] = 0;
                m_ptr[k] = 0; m_rid[k] = 0; m_w[k] = 0; m_sel[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                m_rv[k] = 0;
                if (m_busy[k]) begin
                    if (cyc - m_start[k] == S[k]) m_first[k] = t_dout;
                    if (cyc - m_start[k] == S[k] + XTRA) begin
                        m_rv[k] = 1; m_rdata[k] = m_first[k]; m_rid[k] = m_w[k];
                        m_rerr[k] = (m_first[k] != t_dout); m_busy[k] = 0;
                    end
                end else if (t_req != 4'd0) begin
                    for (int j = 3; j >= 0; j--)
                        if (t_req[(m_ptr[k] + j) % 4]) m_w[k] = (m_ptr[k] + j) % 4;
                    m_busy[k] = 1; m_start[k] = cyc;
                    m_sel[k] = t_sel[m_w[k]*4 +: 4];
                    m_ptr[k] = (m_w[k] + 1) % 4;
                end
            end
        end
    end

    function automatic logic [14:0] model_exp(input int k);
        logic [3:0] g;
        g = m_busy[k] ? (4'b0001 << m_w[k]) : 4'b0000;
        return {g, m_sel[k], m_busy[k], m_rv[k], m_rdata[k], 2'(m_rid[k]), m_busy[k], m_rerr[k]};
    endfunction

    // mux_sel is only defined while busy; rerr only matters with rvalid.
    initial forever begin
        @(negedge CK); #2;
        if (chk_en)
            for (int k = 0; k < 3; k++) begin
                logic [14:0] msk;
                msk = 15'h7FFF;
                if (!m_busy[k]) msk[10:7] = 4'h0;
                if (!m_rv[k])   msk[0]    = 1'b0;
                chk($sformatf("model_S%0d", S[k]), 32'(obs(k) & msk), 32'(model_exp(k) & msk));
            end
    end

    task automatic do_reset();
        @(negedge CK);
        RN = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_S%0d", S[k]), 32'(obs(k)), 32'd0);
        @(negedge CK);
        RN = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] sel;
        logic        dout;
        logic [3:0]  gnt;
        logic [3:0]  msel;
        logic        en;
        logic        rv;
        logic        rd;
        logic [1:0]  rid;
    } vec_t;
    vec_t tbl [8];

    int order [$];
    int lat [3];
    logic [3:0] prev_g;

    initial begin
        RN = 1'b0; t_req = '0; t_sel = '0; t_dout = 1'b0; chk_en = 0;
        tests = 0; fails = 0;
        tbl[0] = '{4'b0001, 16'h0005, 1'b1, 4'b0001, 4'h5, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{4'b0000, 16'h0005, 1'b1, 4'b0001, 4'h5, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[2] = '{4'b0000, 16'h0005, 1'b1, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[3] = '{4'b0000, 16'h0005, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[4] = '{4'b0100, 16'h0A00, 1'b0, 4'b0100, 4'hA, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[5] = '{4'b0000, 16'hFFFF, 1'b0, 4'b0100, 4'hA, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[6] = '{4'b0000, 16'hFFFF, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2};
        tbl[7] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2};

        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("por_S%0d", S[k]), 32'(obs(k)), 32'd0);
        @(negedge CK); @(negedge CK);
        RN = 1'b1;
        chk_en = 1;

`ifndef SCHED_ERRCHK_EN
        // Directed SETTLE=2 read then a one-cycle request pulse from requester 2.
        t_req = tbl[0].req; t_sel = tbl[0].sel; t_dout = tbl[0].dout;
        for (int i = 0; i < 8; i++) begin
            @(negedge CK); #1;
            chk($sformatf("tbl%0d_gnt", i), 32'(if2.gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_en", i), 32'(if2.mux_en), 32'(tbl[i].en));
            if (tbl[i].en) chk($sformatf("tbl%0d_sel", i), 32'(if2.mux_sel), 32'(tbl[i].msel));
            chk($sformatf("tbl%0d_rv", i), 32'(if2.rvalid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rd", i), 32'(if2.rdata), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_rid", i), 32'(if2.rid), 32'(tbl[i].rid));
            if (i < 7) begin t_req = tbl[i+1].req; t_sel = tbl[i+1].sel; t_dout = tbl[i+1].dout; end
        end
`endif

        // All four requesting continuously: rotation 0,1,2,3,0.
        do_reset();
        t_req = 4'hF; t_sel = 16'h3210; prev_g = '0;
        repeat (24) begin
            @(negedge CK); #1;
            if (prev_g == 4'd0 && if2.gnt != 4'd0)
                for (int j = 0; j < 4; j++) if (if2.gnt[j]) order.push_back(j);
            prev_g = if2.gnt;
        end
        t_req = '0;
        chk("rr_count_ge5", 32'(order.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), 32'(i < order.size() ? order[i] : -1), 32'(i % 4));

        // Reset one cycle after granting requester 3, then 0 wins over 3.
        do_reset();
        t_req = 4'b1000; t_sel = 16'h7000;
        @(negedge CK); #1;
        chk("r3_gnt", 32'(if2.gnt), 32'b1000);
        t_req = '0;
        @(negedge CK);
        RN = 1'b0;
        #1;
        chk("midrst_outs", 32'(obs(0)), 32'd0);
        @(negedge CK);
        RN = 1'b1; t_req = 4'b1001;
        @(negedge CK); #1;
        chk("post_rst_gnt", 32'(if2.gnt), 32'b0001);
        t_req = '0;
        repeat (20) @(negedge CK);

        // Latency from the request-sampling edge (counted as edge 1) to rvalid.
        do_reset();
        t_req = 4'b0001; t_dout = 1'b1;
        lat = '{0, 0, 0};
        for (int c = 1; c <= 30; c++) begin
            @(posedge CK); #1;
            t_req = '0;
            if (if2.rvalid  && lat[0] == 0) lat[0] = c;
            if (if1.rvalid  && lat[1] == 0) lat[1] = c;
            if (if15.rvalid && lat[2] == 0) lat[2] = c;
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("latency_S%0d", S[k]), 32'(lat[k]), 32'(S[k] + 1 + XTRA));

`ifdef SCHED_ERRCHK_EN
        // First sample 1, second 0 -> rdata=1, rerr=1; then a stable read.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            t_req = 4'b0001; t_dout = 1'b1;
            @(negedge CK); t_req = '0;
            @(negedge CK);
            @(negedge CK); t_dout = (pass == 1);
            @(negedge CK); #1;
            chk($sformatf("echk%0d_rv", pass), 32'(if2.rvalid), 32'd1);
            chk($sformatf("echk%0d_rd", pass), 32'(if2.rdata), 32'd1);
            chk($sformatf("echk%0d_rerr", pass), 32'(if2.rerr), 32'(pass == 0));
        end
`endif

        // Random traffic with occasional resets; the model checks every cycle.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            @(negedge CK);
            if ($urandom_range(0, 199) == 0) RN = 1'b0;
            else RN = 1'b1;
            t_req  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            t_sel  = 16'($urandom);
            t_dout = 1'($urandom);
        end
        RN = 1'b1;
        repeat (20) @(negedge CK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
